// File: rtl/adc_capture.sv
// Frame capture for two dual-lane serial ADCs: drives chip-select, deserialises four lanes, checks leading zeros.
// Optional ADC_AVERAGE_EN replaces raw outputs with a 4-tap boxcar over accepted samples.
module adc_capture #(
    parameter int QUIET_CYCLES = 2,
    parameter int LEAD_BITS    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        ad_cs,
    input  logic [1:0]  ad_sdata_a,
    input  logic [1:0]  ad_sdata_b,
    output logic [11:0] sample_a0,
    output logic [11:0] sample_a1,
    output logic [11:0] sample_b0,
    output logic [11:0] sample_b1,
    output logic        sample_valid,
    output logic        frame_err,
    output logic [1:0]  dbg_state_o
);

    localparam int FRAME_BITS = LEAD_BITS + 12;
    localparam int CW         = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        QUIET = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] bit_cnt_q;
    logic [3:0]    quiet_cnt_q;
    logic          ad_cs_q;
    logic          lead_err_q;
    logic          done_q;
    logic          valid_q;
    logic          err_q;
    logic [11:0]   shift_q [4];
    logic [11:0]   smp_q   [4];
    logic [11:0]   smp_d   [4];
    logic [3:0]    lane_bits;

    // Lane index: 0 = a0, 1 = a1, 2 = b0, 3 = b1.
    assign lane_bits = {ad_sdata_b[1], ad_sdata_b[0], ad_sdata_a[1], ad_sdata_a[0]};

`ifdef ADC_AVERAGE_EN
    logic [11:0] hist_q [4][3];
    logic [13:0] sum_d  [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sum_d[i] = {2'b00, shift_q[i]} + {2'b00, hist_q[i][0]}
                     + {2'b00, hist_q[i][1]} + {2'b00, hist_q[i][2]};
            smp_d[i] = sum_d[i][13:2];
        end
    end

    // History only advances on accepted frames so rejected data never pollutes the average.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 3; j++) hist_q[i][j] <= '0;
            end
        end else if (done_q && !lead_err_q) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i][2] <= hist_q[i][1];
                hist_q[i][1] <= hist_q[i][0];
                hist_q[i][0] <= shift_q[i];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 4; i++) smp_d[i] = shift_q[i];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            quiet_cnt_q <= '0;
            ad_cs_q     <= 1'b1;
            lead_err_q  <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shift_q[i] <= '0;
                smp_q[i]   <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            // Report the frame one edge after its last bit; shift_q is stable in QUIET.
            if (done_q) begin
                done_q <= 1'b0;
                if (lead_err_q) begin
                    err_q <= 1'b1;
                end else begin
                    valid_q <= 1'b1;
                    for (int i = 0; i < 4; i++) smp_q[i] <= smp_d[i];
                end
            end
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q    <= CONV;
                        ad_cs_q    <= 1'b0;
                        bit_cnt_q  <= '0;
                        lead_err_q <= 1'b0;
                    end
                end
                CONV: begin
                    for (int i = 0; i < 4; i++) shift_q[i] <= {shift_q[i][10:0], lane_bits[i]};
                    if ((bit_cnt_q < CW'(LEAD_BITS)) && (|lane_bits)) lead_err_q <= 1'b1;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CW'(FRAME_BITS - 1)) begin
                        state_q     <= QUIET;
                        ad_cs_q     <= 1'b1;
                        done_q      <= 1'b1;
                        quiet_cnt_q <= '0;
                    end
                end
                QUIET: begin
                    if (quiet_cnt_q == 4'(QUIET_CYCLES - 1)) begin
                        if (enable) begin
                            state_q    <= CONV;
                            ad_cs_q    <= 1'b0;
                            bit_cnt_q  <= '0;
                            lead_err_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        quiet_cnt_q <= quiet_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ad_cs_q <= 1'b1;
                end
            endcase
        end
    end

    assign ad_cs        = ad_cs_q;
    assign sample_a0    = smp_q[0];
    assign sample_a1    = smp_q[1];
    assign sample_b0    = smp_q[2];
    assign sample_b1    = smp_q[3];
    assign sample_valid = valid_q;
    assign frame_err    = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture (default parameters, ADC_AVERAGE_EN undefined).
// A behavioural ADC shifts each lane's 16-bit frame word out on falling edges while ad_cs is low.
module tb_adc_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        ad_cs;
    logic [1:0]  ad_sdata_a;
    logic [1:0]  ad_sdata_b;
    logic [11:0] sample_a0, sample_a1, sample_b0, sample_b1;
    logic        sample_valid;
    logic        frame_err;
    logic [1:0]  dbg_state;

    logic [15:0] frm_a0, frm_a1, frm_b0, frm_b1;
    int          bit_idx;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cnt;
    int          pulses;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;

    always #5 clk = ~clk;

    adc_capture dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ad_cs        (ad_cs),
        .ad_sdata_a   (ad_sdata_a),
        .ad_sdata_b   (ad_sdata_b),
        .sample_a0    (sample_a0),
        .sample_a1    (sample_a1),
        .sample_b0    (sample_b0),
        .sample_b1    (sample_b1),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .dbg_state_o  (dbg_state)
    );

    // ADC model: bit 1 appears on the falling edge after chip-select drops.
    always @(negedge clk) begin
        if (ad_cs !== 1'b0) begin
            bit_idx    = 0;
            ad_sdata_a = 2'b00;
            ad_sdata_b = 2'b00;
        end else begin
            if (bit_idx < 16) begin
                ad_sdata_a = {frm_a1[15 - bit_idx], frm_a0[15 - bit_idx]};
                ad_sdata_b = {frm_b1[15 - bit_idx], frm_b0[15 - bit_idx]};
            end else begin
                ad_sdata_a = 2'b00;
                ad_sdata_b = 2'b00;
            end
            bit_idx = bit_idx + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic [15:0] a0, input logic [15:0] a1,
                             input logic [15:0] b0, input logic [15:0] b1);
        frm_a0 = a0;
        frm_a1 = a1;
        frm_b0 = b0;
        frm_b1 = b1;
    endtask

    task automatic check_samples(input logic [11:0] a0, input logic [11:0] a1,
                                 input logic [11:0] b0, input logic [11:0] b1);
        check("sample_a0", {20'd0, sample_a0}, {20'd0, a0});
        check("sample_a1", {20'd0, sample_a1}, {20'd0, a1});
        check("sample_b0", {20'd0, sample_b0}, {20'd0, b0});
        check("sample_b1", {20'd0, sample_b1}, {20'd0, b1});
    endtask

    // From the edge after ad_cs dropped, run to the final-bit edge counting pulses.
    task automatic run_to_last_bit(input int already);
        pulses = 0;
        for (int i = already; i < 16; i++) begin
            tick();
            if (i < 15) pulses += int'(sample_valid) + int'(frame_err);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        set_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", {31'd0, ad_cs}, 32'd1);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check_samples(12'h000, 12'h000, 12'h000, 12'h000);

        @(negedge clk);
        reset = 1'b0;
        tick();
        check("idle_no_enable_cs", {31'd0, ad_cs}, 32'd1);

        // Frame 1: clean data, period and latency.
        set_frame(16'h0ABC, 16'h0123, 16'h0FFF, 16'h0000);
        @(negedge clk);
        enable = 1'b1;
        tick();
        check("f1_cs_low", {31'd0, ad_cs}, 32'd0);
        check("f1_state_conv", {30'd0, dbg_state}, {30'd0, ST_CONV});
        cnt = 1;
        pulses = 0;
        repeat (15) begin
            tick();
            if (ad_cs == 1'b0) cnt++;
            pulses += int'(sample_valid) + int'(frame_err);
        end
        check("f1_low_cycles", cnt, 16);
        check("f1_no_early_pulse", pulses, 0);
        tick();
        check("f1_cs_high", {31'd0, ad_cs}, 32'd1);
        check("f1_valid_not_yet", {31'd0, sample_valid}, 32'd0);
        tick();
        check("f1_cs_quiet", {31'd0, ad_cs}, 32'd1);
        check("f1_valid", {31'd0, sample_valid}, 32'd1);
        check("f1_err", {31'd0, frame_err}, 32'd0);
        check_samples(12'hABC, 12'h123, 12'hFFF, 12'h000);

        // Frame 2: b1 leading bit 2 set -> rejected.
        set_frame(16'h0111, 16'h0222, 16'h0333, 16'h4555);
        tick();
        check("f2_cs_low_no_gap", {31'd0, ad_cs}, 32'd0);
        check("f1_valid_one_cycle", {31'd0, sample_valid}, 32'd0);
        run_to_last_bit(0);
        check("f2_no_early_pulse", pulses, 0);
        tick();
        check("f2_err", {31'd0, frame_err}, 32'd1);
        check("f2_valid", {31'd0, sample_valid}, 32'd0);
        check_samples(12'hABC, 12'h123, 12'hFFF, 12'h000);

        // Frame 3: enable dropped at bit 5; frame still completes.
        set_frame(16'h0001, 16'h0800, 16'h07FF, 16'h0A5A);
        tick();
        check("f2_err_one_cycle", {31'd0, frame_err}, 32'd0);
        check("f3_cs_low", {31'd0, ad_cs}, 32'd0);
        repeat (5) tick();
        enable = 1'b0;
        run_to_last_bit(5);
        tick();
        check("f3_valid", {31'd0, sample_valid}, 32'd1);
        check("f3_err", {31'd0, frame_err}, 32'd0);
        check_samples(12'h001, 12'h800, 12'h7FF, 12'hA5A);
        tick();
        cnt = 0;
        repeat (5) begin
            tick();
            if (ad_cs == 1'b1 && dbg_state == ST_IDLE) cnt++;
        end
        check("f3_stays_idle", cnt, 5);

        // Frame 4: reset at bit 8 discards the partial frame.
        set_frame(16'h0111, 16'h0111, 16'h0111, 16'h0111);
        @(negedge clk);
        enable = 1'b1;
        tick();
        check("f4_cs_low", {31'd0, ad_cs}, 32'd0);
        repeat (8) tick();
        #2;
        reset = 1'b1;
        #1;
        check("f4_rst_cs_async", {31'd0, ad_cs}, 32'd1);
        check("f4_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check_samples(12'h000, 12'h000, 12'h000, 12'h000);
        pulses = 0;
        repeat (2) begin
            tick();
            pulses += int'(sample_valid) + int'(frame_err);
        end
        check("f4_rst_no_pulse", pulses, 0);

        // Frame 5: first frame after reset release.
        set_frame(16'h0FED, 16'h00F0, 16'h03C3, 16'h0999);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("f5_cs_low", {31'd0, ad_cs}, 32'd0);
        run_to_last_bit(0);
        check("f5_no_early_pulse", pulses, 0);
        tick();
        check("f5_valid", {31'd0, sample_valid}, 32'd1);
        check("f5_err", {31'd0, frame_err}, 32'd0);
        check_samples(12'hFED, 12'h0F0, 12'h3C3, 12'h999);

        enable = 1'b0;
        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
